matrix_operand_loader: RTL and testbench

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

---
 rtl/matrix_operand_loader.sv | 136 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_operand_loader.sv
// Matrix operand loader: collects two DIM x DIM matrices (A then B) one
// element at a time from an upstream valid/ready stream. It then offers them
// to the multiplier data-in bus as two packed words, A first and then B.
//
// Ports:
//   clk        - clock, rising edge
//   slapOff    - asynchronous active-low reset
//   clear      - synchronous abort of any partial load or pending send
//   in_valid   - upstream element valid
//   in_data    - element value, row-major, A first then B
//   in_ready   - loader accepts an element this cycle (decoded from state)
//   bus_out    - packed matrix word (element k at [k*ELEM_W +: ELEM_W])
//   bus_valid  - bus_out holds a word offered to the multiplier
//   bus_ready  - multiplier accepts the offered word
//   pairs_sent - completed A+B pairs, wraps at 256
module matrix_operand_loader #(
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned DIM    = 4
) (
    input  logic                       clk,
    input  logic                       slapOff,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [ELEM_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [DIM*DIM*ELEM_W-1:0]  bus_out,
    output logic                       bus_valid,
    input  logic                       bus_ready,
    output logic [7:0]                 pairs_sent
);

    localparam int unsigned N     = DIM * DIM;
    localparam int unsigned BUS_W = N * ELEM_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        FILL_A = 2'd0,
        FILL_B = 2'd1,
        SEND_A = 2'd2,
        SEND_B = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [BUS_W-1:0]   a_q;
    logic [BUS_W-1:0]   b_q;
    logic               xfer;
    logic               last;

    assign xfer = in_valid && in_ready;
    assign last = (idx == IDX_W'(N - 1));

    // State register
    always_ff @(posedge clk or negedge slapOff) begin
        if (!slapOff) begin
            state <= FILL_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear overrides any transfer or bus acceptance
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = FILL_A;
        end else begin
            case (state)
                FILL_A: if (xfer && last) state_next = FILL_B;
                FILL_B: if (xfer && last) state_next = SEND_A;
                SEND_A: if (bus_ready)    state_next = SEND_B;
                SEND_B: if (bus_ready)    state_next = FILL_A;
                default:                  state_next = FILL_A;
            endcase
        end
    end

    // Output decode: upstream is accepted only while filling
    always_comb begin
        in_ready = 1'b0;
        case (state)
            FILL_A, FILL_B: in_ready = 1'b1;
            default:        in_ready = 1'b0;
        endcase
    end

    // Datapath: element capture, bus word staging and pair counter
    always_ff @(posedge clk or negedge slapOff) begin
        if (!slapOff) begin
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            bus_out    <= '0;
            bus_valid  <= 1'b0;
            pairs_sent <= '0;
        end else if (clear) begin
            // Abort keeps matrix registers, bus_out and the counter intact
            idx       <= '0;
            bus_valid <= 1'b0;
        end else begin
            case (state)
                FILL_A: begin
                    if (xfer) begin
                        a_q[32'(idx) * ELEM_W +: ELEM_W] <= in_data;
                        idx <= last ? '0 : idx + IDX_W'(1);
                    end
                end
                FILL_B: begin
                    if (xfer) begin
                        b_q[32'(idx) * ELEM_W +: ELEM_W] <= in_data;
                        idx <= last ? '0 : idx + IDX_W'(1);
                        if (last) begin
                            bus_out   <= a_q;
                            bus_valid <= 1'b1;
                        end
                    end
                end
                SEND_A: begin
                    if (bus_ready) begin
                        bus_out <= b_q;
                    end
                end
                SEND_B: begin
                    if (bus_ready) begin
                        bus_valid  <= 1'b0;
                        pairs_sent <= pairs_sent + 8'd1;
                        idx        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Testbench for matrix_operand_loader: random element streams with upstream
// gaps and bus backpressure, compared against packed words built from the
// element lists and a software pair counter.
module tb_matrix_operand_loader;

    localparam int unsigned ELEM_W = 16;
    localparam int unsigned DIM    = 4;
    localparam int unsigned N      = DIM * DIM;
    localparam int unsigned BW     = N * ELEM_W;

    logic              clk = 1'b0;
    logic              slapOff;
    logic              clear;
    logic              in_valid;
    logic [ELEM_W-1:0] in_data;
    logic              in_ready;
    logic [BW-1:0]     bus_out;
    logic              bus_valid;
    logic              bus_ready;
    logic [7:0]        pairs_sent;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [ELEM_W-1:0] a_el [N];
    logic [ELEM_W-1:0] b_el [N];
    logic [7:0]        exp_pairs;

    always #5 clk = ~clk;

    matrix_operand_loader #(.ELEM_W(ELEM_W), .DIM(DIM)) dut (
        .clk        (clk),
        .slapOff    (slapOff),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .bus_out    (bus_out),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .pairs_sent (pairs_sent)
    );

    // Count bus words actually handed to the multiplier
    always @(posedge clk) begin
        if (slapOff && !clear && bus_valid && bus_ready) n_acc++;
    end

    // Row-major packing: element k of the matrix lands at [k*ELEM_W +: ELEM_W]
    function automatic logic [BW-1:0] pack(input bit sel_b);
        logic [BW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(N); k++) begin
            w[k*ELEM_W +: ELEM_W] = sel_b ? b_el[k] : a_el[k];
        end
        return w;
    endfunction

    task automatic rand_pair();
        for (int k = 0; k < int'(N); k++) begin
            a_el[k] = ELEM_W'($urandom);
            b_el[k] = ELEM_W'($urandom);
        end
    endtask

    // Stream A then B with optional idle gaps; ends at the negedge after the last transfer
    task automatic fill_pair(input int gap_pct);
        for (int k = 0; k < int'(2 * N); k++) begin
            for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
                @(negedge clk);
                in_valid  = 1'b0;
                in_data   = ELEM_W'($urandom);
                bus_ready = 1'($urandom);
            end
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL fill_in_ready k=%0d: got %b expected 1", k, in_ready);
            end
            in_valid  = 1'b1;
            in_data   = (k < int'(N)) ? a_el[k] : b_el[k - int'(N)];
            bus_ready = 1'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        bus_ready = 1'b0;
        n_vec++;
        if (bus_valid !== 1'b1) begin
            n_err++; $display("FAIL send_a_valid: got %b expected 1", bus_valid);
        end
        n_vec++;
        if (bus_out !== pack(1'b0)) begin
            n_err++; $display("FAIL send_a_word: got %h expected %h", bus_out, pack(1'b0));
        end
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL send_in_ready: got %b expected 0", in_ready);
        end
    endtask

    // Deliver A then B with the given number of refused cycles on each word
    task automatic drain(input int stall_a, input int stall_b);
        for (int s = 0; s < stall_a; s++) begin
            bus_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = ELEM_W'($urandom);
            @(negedge clk);
            n_vec++;
            if (bus_valid !== 1'b1 || bus_out !== pack(1'b0) || in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_a: got v=%b r=%b %h expected v=1 r=0 %h", bus_valid, in_ready, bus_out, pack(1'b0));
            end
        end
        in_valid  = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus_valid !== 1'b1 || bus_out !== pack(1'b1)) begin
            n_err++; $display("FAIL send_b_word: got v=%b %h expected v=1 %h", bus_valid, bus_out, pack(1'b1));
        end
        for (int s = 0; s < stall_b; s++) begin
            bus_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = ELEM_W'($urandom);
            @(negedge clk);
            n_vec++;
            if (bus_valid !== 1'b1 || bus_out !== pack(1'b1) || in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_b: got v=%b r=%b %h expected v=1 r=0 %h", bus_valid, in_ready, bus_out, pack(1'b1));
            end
        end
        in_valid  = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        exp_pairs = exp_pairs + 8'd1;
        n_vec++;
        if (bus_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL pair_done: got v=%b r=%b expected v=0 r=1", bus_valid, in_ready);
        end
        n_vec++;
        if (pairs_sent !== exp_pairs) begin
            n_err++; $display("FAIL pairs_sent: got %0d expected %0d", pairs_sent, exp_pairs);
        end
        n_vec++;
        if (bus_out !== pack(1'b1)) begin
            n_err++; $display("FAIL bus_hold: got %h expected %h", bus_out, pack(1'b1));
        end
    endtask

    task automatic set_basic();
        a_el = '{16'd5, 16'd8, 16'd9, 16'd2, 16'd7, 16'd3, 16'd8, 16'd4,
                 16'd6, 16'd5, 16'd4, 16'd3, 16'd8, 16'd5, 16'd7, 16'd6};
        b_el = '{16'd11, 16'd14, 16'd19, 16'd18, 16'd6, 16'd9, 16'd3, 16'd5,
                 16'd12, 16'd10, 16'd15, 16'd14, 16'd1, 16'd3, 16'd5, 16'd7};
    endtask

    task automatic test_reset();
        slapOff = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; bus_ready = 1'b0;
        exp_pairs = 8'd0;
        #12;
        n_vec++;
        if (bus_valid !== 1'b0 || bus_out !== '0 || pairs_sent !== 8'd0) begin
            n_err++; $display("FAIL reset_outputs: got v=%b p=%0d %h expected v=0 p=0 0", bus_valid, pairs_sent, bus_out);
        end
        @(negedge clk);
        slapOff = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        set_basic();
        fill_pair(0);
        n_vec++;
        if (bus_out[15:0] !== 16'd5 || bus_out[31:16] !== 16'd8 || bus_out[255:240] !== 16'd6) begin
            n_err++; $display("FAIL basic_a_slices: got %0d %0d %0d expected 5 8 6", bus_out[15:0], bus_out[31:16], bus_out[255:240]);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (bus_valid !== 1'b1 || bus_out[15:0] !== 16'd11 || bus_out[255:240] !== 16'd7) begin
            n_err++; $display("FAIL basic_b_slices: got v=%b %0d %0d expected v=1 11 7", bus_valid, bus_out[15:0], bus_out[255:240]);
        end
        @(negedge clk);
        bus_ready = 1'b0;
        exp_pairs = exp_pairs + 8'd1;
        n_vec++;
        if (bus_valid !== 1'b0 || pairs_sent !== exp_pairs) begin
            n_err++; $display("FAIL basic_done: got v=%b p=%0d expected v=0 p=%0d", bus_valid, pairs_sent, exp_pairs);
        end
    endtask

    task automatic test_backpressure();
        int acc0;
        set_basic();
        fill_pair(0);
        acc0 = n_acc;
        drain(5, 3);
        n_vec++;
        if (n_acc - acc0 !== 2) begin
            n_err++; $display("FAIL bp_acceptances: got %0d expected 2", n_acc - acc0);
        end
    endtask

    task automatic test_gaps();
        set_basic();
        fill_pair(40);
        drain(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        for (int p = 0; p < 4; p++) begin
            rand_pair();
            fill_pair(50);
            drain(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
        end
    endtask

    task automatic test_clear_fill();
        rand_pair();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = (k < int'(N)) ? ELEM_W'($urandom) : ELEM_W'($urandom);
        end
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = ELEM_W'($urandom); bus_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0; bus_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || bus_valid !== 1'b0 || pairs_sent !== exp_pairs) begin
            n_err++; $display("FAIL clear_fill: got r=%b v=%b p=%0d expected r=1 v=0 p=%0d", in_ready, bus_valid, pairs_sent, exp_pairs);
        end
        fill_pair(20);
        drain(1, 0);
    endtask

    task automatic test_clear_send();
        rand_pair();
        fill_pair(0);
        clear = 1'b1; bus_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0; bus_ready = 1'b0;
        n_vec++;
        if (bus_valid !== 1'b0 || in_ready !== 1'b1 || pairs_sent !== exp_pairs || bus_out !== pack(1'b0)) begin
            n_err++; $display("FAIL clear_send: got v=%b r=%b p=%0d %h expected v=0 r=1 p=%0d %h", bus_valid, in_ready, pairs_sent, bus_out, exp_pairs, pack(1'b0));
        end
        rand_pair();
        fill_pair(10);
        drain(0, 2);
    endtask

    task automatic test_async_reset();
        rand_pair();
        fill_pair(0);
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        #2 slapOff = 1'b0;
        #1;
        exp_pairs = 8'd0;
        n_vec++;
        if (bus_valid !== 1'b0 || bus_out !== '0 || pairs_sent !== exp_pairs) begin
            n_err++; $display("FAIL async_reset: got v=%b p=%0d %h expected v=0 p=0 0", bus_valid, pairs_sent, bus_out);
        end
        @(negedge clk);
        slapOff = 1'b1;
        rand_pair();
        fill_pair(20);
        drain(2, 1);
    endtask

    task automatic test_wrap();
        @(negedge clk);
        slapOff = 1'b0;
        @(negedge clk);
        slapOff = 1'b1;
        exp_pairs = 8'd0;
        for (int p = 0; p < 256; p++) begin
            rand_pair();
            fill_pair(0);
            drain(0, 0);
        end
        n_vec++;
        if (pairs_sent !== 8'd0) begin
            n_err++; $display("FAIL wrap_256: got %0d expected 0", pairs_sent);
        end
        rand_pair();
        fill_pair(0);
        drain(0, 0);
        n_vec++;
        if (pairs_sent !== 8'd1) begin
            n_err++; $display("FAIL wrap_257: got %0d expected 1", pairs_sent);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_clear_fill();
        test_clear_send();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
